// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch control and counter stages.
// STOPWATCH_LAP_EN adds a third (lap) button channel.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'b100,
        CLEAR   = 3'b010,
        RUNNING = 3'b001
    } state_t;

    localparam int BTN_START = 0;
    localparam int BTN_CLEAR = 1;
    localparam int BTN_LAP   = 2;

`ifdef STOPWATCH_LAP_EN
    localparam int NUM_BTN = 3;
`else
    localparam int NUM_BTN = 2;
`endif

    function automatic logic is_one_hot(input logic [2:0] s);
        return (s != 3'b000) && ((s & (s - 3'b001)) == 3'b000);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and run-state outputs of the stopwatch control stage.
// STOPWATCH_LAP_EN adds lap_btn / lap_hold.
interface stopwatch_ctrl_if;
    import stopwatch_pkg::*;

    logic   start_stop_btn;
    logic   clear_btn;
    state_t state;
    logic   sec_pulse;
`ifdef STOPWATCH_LAP_EN
    logic   lap_btn;
    logic   lap_hold;

    modport master (output start_stop_btn, output clear_btn, output lap_btn,
                    input state, input sec_pulse, input lap_hold);
    modport slave  (input start_stop_btn, input clear_btn, input lap_btn,
                    output state, output sec_pulse, output lap_hold);
`else
    modport master (output start_stop_btn, output clear_btn,
                    input state, input sec_pulse);
    modport slave  (input start_stop_btn, input clear_btn,
                    output state, output sec_pulse);
`endif

endinterface

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Per-button synchroniser, debouncer and rising-edge press detector.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 200_000
) (
    input  logic clk,
    input  logic nrst,
    input  logic btn_raw,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CW-1:0]          cnt_reg, cnt_next;
    logic                   deb_reg, deb_next;
    logic                   deb_prev_reg;
    logic                   press_reg;
    logic                   synced;

    assign synced = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], btn_raw};
        end
    end

    // Any return to agreement restarts the stability count from zero.
    always_comb begin
        cnt_next = '0;
        deb_next = deb_reg;
        if (synced != deb_reg) begin
            if (cnt_reg == CNT_LAST) begin
                deb_next = ~deb_reg;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_reg      <= '0;
            deb_reg      <= 1'b0;
            deb_prev_reg <= 1'b0;
            press_reg    <= 1'b0;
        end else begin
            cnt_reg      <= cnt_next;
            deb_reg      <= deb_next;
            deb_prev_reg <= deb_reg;
            press_reg    <= deb_reg & ~deb_prev_reg;
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front end: button debouncing, run-state FSM and seconds prescaler.
// STOPWATCH_LAP_EN adds a lap button toggling lap_hold.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int PULSE_DIV       = 10_000_000,
    parameter int DEBOUNCE_CYCLES = 200_000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic             clk,
    input  logic             nrst,
    stopwatch_ctrl_if.slave  ctl
);

    localparam int PW = $clog2(PULSE_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PULSE_DIV - 1);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_press;

    assign btn_raw[BTN_START] = ctl.start_stop_btn;
    assign btn_raw[BTN_CLEAR] = ctl.clear_btn;
`ifdef STOPWATCH_LAP_EN
    assign btn_raw[BTN_LAP]   = ctl.lap_btn;
`endif

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_debounce #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk     (clk),
                .nrst    (nrst),
                .btn_raw (btn_raw[gi]),
                .press   (btn_press[gi])
            );
        end
    endgenerate

    state_t state_reg, state_next;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Clear has priority over start; presses seen while in CLEAR are ignored.
    always_comb begin
        state_next = state_reg;
        if (!is_one_hot(state_reg)) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (btn_press[BTN_CLEAR])      state_next = CLEAR;
                    else if (btn_press[BTN_START]) state_next = RUNNING;
                end
                RUNNING: begin
                    if (btn_press[BTN_CLEAR])      state_next = CLEAR;
                    else if (btn_press[BTN_START]) state_next = IDLE;
                end
                CLEAR:   state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    logic [PW-1:0] presc_reg, presc_next;

    // IDLE holds the partial second so a resume continues where it paused.
    always_comb begin
        presc_next = presc_reg;
        case (state_reg)
            RUNNING: presc_next = (presc_reg == PRESC_LAST) ? '0 : presc_reg + 1'b1;
            CLEAR:   presc_next = '0;
            default: presc_next = presc_reg;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_next;
        end
    end

    assign ctl.state     = state_reg;
    assign ctl.sec_pulse = (state_reg == RUNNING) && (presc_reg == PRESC_LAST);

`ifdef STOPWATCH_LAP_EN
    logic lap_hold_reg, lap_hold_next;

    always_comb begin
        lap_hold_next = lap_hold_reg;
        if (state_reg == CLEAR || btn_press[BTN_CLEAR]) begin
            lap_hold_next = 1'b0;
        end else if (btn_press[BTN_LAP] && (state_reg == RUNNING || state_reg == IDLE)) begin
            lap_hold_next = ~lap_hold_reg;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            lap_hold_reg <= 1'b0;
        end else begin
            lap_hold_reg <= lap_hold_next;
        end
    end

    assign ctl.lap_hold = lap_hold_reg;
`endif

endmodule
